// File: rtl/uart_word_assembler_pkg.sv
// Shared constants and state encoding for the UART receive-side stages.
package uart_pkg;

    localparam int BYTES_PER_WORD       = 4;
    localparam int DEFAULT_TIMEOUT_CLKS = 2_000_000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } asm_state_e;

endpackage

// File: rtl/uart_word_assembler_if.sv
// Byte-in / word-out bundle between the UART receiver, the assembler and its consumer.
interface uart_word_assembler_if;

    logic [7:0]  i_byte;
    logic        i_done;
    logic [31:0] o_word;
    logic        o_valid;
    logic        i_ready;
    logic [2:0]  o_count;
    logic        o_timeout;
    logic        o_overrun;
    logic        i_clear_err;

    modport master (
        output i_byte, i_done, i_ready, i_clear_err,
        input  o_word, o_valid, o_count, o_timeout, o_overrun
    );

    modport slave (
        input  i_byte, i_done, i_ready, i_clear_err,
        output o_word, o_valid, o_count, o_timeout, o_overrun
    );

endinterface

// File: rtl/uart_word_assembler_pulse_rise_det.sv
// Rising-edge detector for level strobes; an input already high out of reset
// must be seen low once before it can produce a pulse.
module pulse_rise_det (
    input  logic clock,
    input  logic reset_n,
    input  logic sig_i,
    output logic pulse_o
);

    logic done_q;
    logic seen_low_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_q     <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            done_q <= sig_i;
            if (!sig_i) begin
                seen_low_q <= 1'b1;
            end
        end
    end

    assign pulse_o = sig_i & ~done_q & seen_low_q;

endmodule

// File: rtl/uart_word_assembler.sv
// Packs four received bytes (LSB first) into a 32-bit word with valid/ready
// output, inter-byte timeout and a sticky overrun flag.
module uart_word_assembler
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
    input logic                  clock,
    input logic                  reset_n,
    uart_word_assembler_if.slave bus
);

    localparam int            TW         = $clog2(TIMEOUT_CLKS + 1);
    // Terminal compare one below TIMEOUT_CLKS-1: the edge that would reach it fires instead.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 2);

    asm_state_e    state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   word_q, word_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          timeout_q, timeout_d;
    logic          overrun_q, overrun_d;
    logic          overrun_set;
    logic          accept;
    logic          byte_ev;

    pulse_rise_det u_rise (
        .clock   (clock),
        .reset_n (reset_n),
        .sig_i   (bus.i_done),
        .pulse_o (byte_ev)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            word_q    <= 32'd0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        word_d      = word_q;
        timer_d     = timer_q;
        timeout_d   = 1'b0;
        overrun_set = 1'b0;
        accept      = (state_q == ST_HOLD) && bus.i_ready;

        case (state_q)
            ST_IDLE: begin
                if (byte_ev) begin
                    word_d  = {24'd0, bus.i_byte};
                    idx_d   = 2'd1;
                    timer_d = '0;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (byte_ev) begin
                    word_d[{idx_q, 3'b000} +: 8] = bus.i_byte;
                    timer_d = '0;
                    if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
                        idx_d   = 2'd0;
                        state_d = ST_HOLD;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    word_d    = 32'd0;
                    idx_d     = 2'd0;
                    timer_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    timer_d = '0;
                    // A byte arriving on the accepting edge starts the next word without a bubble.
                    if (byte_ev) begin
                        word_d  = {24'd0, bus.i_byte};
                        idx_d   = 2'd1;
                        state_d = ST_COLLECT;
                    end else begin
                        word_d  = 32'd0;
                        idx_d   = 2'd0;
                        state_d = ST_IDLE;
                    end
                end else if (byte_ev) begin
                    overrun_set = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
                word_d  = 32'd0;
                timer_d = '0;
            end
        endcase

        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (bus.i_clear_err) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    assign bus.o_word    = word_q;
    assign bus.o_valid   = (state_q == ST_HOLD);
    assign bus.o_count   = (state_q == ST_HOLD) ? 3'(BYTES_PER_WORD) : {1'b0, idx_q};
    assign bus.o_timeout = timeout_q;
    assign bus.o_overrun = overrun_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_uart_word_assembler;

    localparam int TO = 100;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    uart_word_assembler_if bus ();

    uart_word_assembler #(.TIMEOUT_CLKS(TO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int ecyc = 0;
    int valid_cycles = 0;
    int last_ev = 0;
    logic [31:0] acc_q[$];
    int          to_q[$];

    // reference model state
    logic [7:0]  m_cur[$];
    logic        m_held;
    logic [31:0] m_hw;
    int          m_gap;
    logic        m_ovr;
    logic        m_prev;
    logic        m_to;

    always @(posedge clock) ecyc++;

    always @(negedge clock) begin
        if (reset_n && bus.o_valid) begin
            valid_cycles++;
            if (bus.i_ready) acc_q.push_back(bus.o_word);
        end
        if (bus.o_timeout) to_q.push_back(ecyc);
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_byte(input logic [7:0] b, input int hold);
        bus.i_byte = b;
        bus.i_done = 1'b1;
        repeat (hold) tick();
        last_ev = ecyc - hold + 1;
        bus.i_done = 1'b0;
        tick();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
    endtask

    function automatic logic [31:0] first_acc();
        return (acc_q.size() > 0) ? acc_q[0] : 32'hxxxx_xxxx;
    endfunction

    task automatic test_reset();
        bus.i_byte = 8'h00; bus.i_done = 1'b0; bus.i_ready = 1'b0; bus.i_clear_err = 1'b0;
        reset_n = 1'b0;
        tick();
        checks++; if (bus.o_word !== 32'd0) begin errors++; $display("FAIL reset_word: got %h expected 0", bus.o_word); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
        checks++; if (bus.o_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.o_count); end
        checks++; if (bus.o_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", bus.o_timeout); end
        checks++; if (bus.o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.o_overrun); end
        tick();
        reset_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_basic();
        acc_q.delete(); valid_cycles = 0;
        bus.i_ready = 1'b1;
        pulse_byte(8'h0F, 1);
        pulse_byte(8'hAB, 1);
        checks++; if (bus.o_count !== 3'd2) begin errors++; $display("FAIL basic_midcount: got %0d expected 2", bus.o_count); end
        pulse_byte(8'hCD, 1);
        pulse_byte(8'hEF, 1);
        tick();
        checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL basic_nwords: got %0d expected 1", acc_q.size()); end
        checks++; if (first_acc() !== 32'hEFCDAB0F) begin errors++; $display("FAIL basic_word: got %h expected efcdab0f", first_acc()); end
        checks++; if (valid_cycles != 1) begin errors++; $display("FAIL basic_validcycles: got %0d expected 1", valid_cycles); end
        checks++; if (bus.o_count !== 3'd0) begin errors++; $display("FAIL basic_endcount: got %0d expected 0", bus.o_count); end
    endtask

    task automatic test_long_done();
        logic [7:0] bs [4];
        bs[0] = 8'h11; bs[1] = 8'h22; bs[2] = 8'h33; bs[3] = 8'h44;
        acc_q.delete(); valid_cycles = 0;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse_byte(bs[i], 5);
            checks++; if (bus.o_count !== 3'(i + 1)) begin errors++; $display("FAIL long_count%0d: got %0d expected %0d", i, bus.o_count, i + 1); end
        end
        pulse_byte(bs[3], 5);
        tick();
        checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL long_nwords: got %0d expected 1", acc_q.size()); end
        checks++; if (first_acc() !== 32'h44332211) begin errors++; $display("FAIL long_word: got %h expected 44332211", first_acc()); end
        checks++; if (valid_cycles != 1) begin errors++; $display("FAIL long_validcycles: got %0d expected 1", valid_cycles); end
    endtask

    task automatic test_timeout();
        int e2;
        acc_q.delete(); to_q.delete();
        bus.i_ready = 1'b1;
        pulse_byte(8'h01, 1);
        pulse_byte(8'h02, 1);
        e2 = last_ev;
        while (ecyc < e2 + TO - 2) tick();
        checks++; if (bus.o_count !== 3'd2 || to_q.size() != 0) begin errors++; $display("FAIL timeout_early: count %0d timeouts %0d, expected 2 and 0", bus.o_count, to_q.size()); end
        while (ecyc < e2 + TO + 10) tick();
        checks++; if (to_q.size() != 1) begin errors++; $display("FAIL timeout_npulses: got %0d expected 1", to_q.size()); end
        checks++; if (to_q.size() > 0 && to_q[0] != e2 + TO - 1) begin errors++; $display("FAIL timeout_edge: got %0d expected %0d", to_q[0], e2 + TO - 1); end
        checks++; if (bus.o_count !== 3'd0) begin errors++; $display("FAIL timeout_count: got %0d expected 0", bus.o_count); end
        pulse_byte(8'h10, 1);
        pulse_byte(8'h20, 1);
        pulse_byte(8'h30, 1);
        pulse_byte(8'h40, 1);
        tick();
        checks++; if (acc_q.size() != 1 || first_acc() !== 32'h40302010) begin errors++; $display("FAIL timeout_nextword: got %h (n=%0d) expected 40302010", first_acc(), acc_q.size()); end
    endtask

    task automatic test_overrun();
        acc_q.delete(); to_q.delete();
        bus.i_ready = 1'b0;
        pulse_byte(8'hA1, 1);
        pulse_byte(8'hB2, 1);
        pulse_byte(8'hC3, 1);
        pulse_byte(8'hD4, 1);
        checks++; if (bus.o_valid !== 1'b1 || bus.o_count !== 3'd4) begin errors++; $display("FAIL ovr_hold: valid %b count %0d expected 1 and 4", bus.o_valid, bus.o_count); end
        checks++; if (bus.o_word !== 32'hD4C3B2A1) begin errors++; $display("FAIL ovr_word: got %h expected d4c3b2a1", bus.o_word); end
        pulse_byte(8'h55, 1);
        checks++; if (bus.o_word !== 32'hD4C3B2A1) begin errors++; $display("FAIL ovr_wordkept: got %h expected d4c3b2a1", bus.o_word); end
        checks++; if (bus.o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", bus.o_overrun); end
        repeat (150) tick();
        checks++; if (bus.o_valid !== 1'b1 || to_q.size() != 0) begin errors++; $display("FAIL ovr_notimeout: valid %b timeouts %0d expected 1 and 0", bus.o_valid, to_q.size()); end
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL ovr_validfall: got %b expected 0", bus.o_valid); end
        checks++; if (acc_q.size() != 1 || first_acc() !== 32'hD4C3B2A1) begin errors++; $display("FAIL ovr_accept: got %h expected d4c3b2a1", first_acc()); end
        checks++; if (bus.o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", bus.o_overrun); end
        bus.i_clear_err = 1'b1;
        tick();
        bus.i_clear_err = 1'b0;
        checks++; if (bus.o_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", bus.o_overrun); end
    endtask

    task automatic test_back_to_back();
        acc_q.delete();
        bus.i_ready = 1'b0;
        pulse_byte(8'h01, 1);
        pulse_byte(8'h02, 1);
        pulse_byte(8'h03, 1);
        pulse_byte(8'h04, 1);
        bus.i_byte = 8'h11; bus.i_done = 1'b1; bus.i_ready = 1'b1;
        tick();
        bus.i_done = 1'b0; bus.i_ready = 1'b0;
        checks++; if (acc_q.size() != 1 || first_acc() !== 32'h04030201) begin errors++; $display("FAIL b2b_accept: got %h expected 04030201", first_acc()); end
        checks++; if (bus.o_count !== 3'd1) begin errors++; $display("FAIL b2b_count: got %0d expected 1", bus.o_count); end
        checks++; if (bus.o_overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", bus.o_overrun); end
        tick();
        bus.i_ready = 1'b1;
        pulse_byte(8'h22, 1);
        pulse_byte(8'h33, 1);
        pulse_byte(8'h44, 1);
        tick();
        checks++; if (acc_q.size() != 2 || acc_q[acc_q.size()-1] !== 32'h44332211) begin errors++; $display("FAIL b2b_second: n=%0d expected 2 words ending 44332211", acc_q.size()); end
    endtask

    task automatic test_clear_vs_set();
        bus.i_ready = 1'b0;
        pulse_byte(8'h61, 1);
        pulse_byte(8'h62, 1);
        pulse_byte(8'h63, 1);
        pulse_byte(8'h64, 1);
        bus.i_byte = 8'h66; bus.i_done = 1'b1; bus.i_clear_err = 1'b1;
        tick();
        bus.i_done = 1'b0; bus.i_clear_err = 1'b0;
        checks++; if (bus.o_overrun !== 1'b1) begin errors++; $display("FAIL setwins: got %b expected 1", bus.o_overrun); end
        bus.i_ready = 1'b1;
        tick();
        bus.i_clear_err = 1'b1;
        tick();
        bus.i_clear_err = 1'b0;
    endtask

    task automatic test_byte_vs_timeout();
        int e1;
        acc_q.delete(); to_q.delete();
        bus.i_ready = 1'b1;
        pulse_byte(8'hAA, 1);
        e1 = last_ev;
        while (ecyc < e1 + TO - 2) tick();
        bus.i_byte = 8'hBB; bus.i_done = 1'b1;
        tick();
        bus.i_done = 1'b0;
        checks++; if (bus.o_count !== 3'd2) begin errors++; $display("FAIL bvt_count: got %0d expected 2", bus.o_count); end
        checks++; if (to_q.size() != 0) begin errors++; $display("FAIL bvt_timeout: got %0d pulses expected 0", to_q.size()); end
        tick();
        pulse_byte(8'hCC, 1);
        pulse_byte(8'hDD, 1);
        tick();
        checks++; if (acc_q.size() != 1 || first_acc() !== 32'hDDCCBBAA) begin errors++; $display("FAIL bvt_word: got %h expected ddccbbaa", first_acc()); end
    endtask

    task automatic test_reset_mid();
        acc_q.delete();
        bus.i_ready = 1'b1;
        pulse_byte(8'h71, 1);
        pulse_byte(8'h72, 1);
        pulse_byte(8'h73, 1);
        reset_n = 1'b0;
        #1;
        checks++; if (bus.o_count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", bus.o_count); end
        tick();
        bus.i_byte = 8'h99; bus.i_done = 1'b1;
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        checks++; if (bus.o_count !== 3'd0) begin errors++; $display("FAIL rstmid_highdone: got %0d expected 0", bus.o_count); end
        bus.i_done = 1'b0;
        tick();
        pulse_byte(8'h9A, 1);
        pulse_byte(8'hBC, 1);
        pulse_byte(8'hDE, 1);
        pulse_byte(8'hF0, 1);
        tick();
        checks++; if (acc_q.size() != 1 || first_acc() !== 32'hF0DEBC9A) begin errors++; $display("FAIL rstmid_word: got %h (n=%0d) expected f0debc9a", first_acc(), acc_q.size()); end
    endtask

    task automatic rand_cycle(input logic d, input logic [7:0] b, input logic rdy, input logic clr);
        logic ev;
        logic ovr_set;
        ev      = d && !m_prev;
        m_prev  = d;
        ovr_set = 1'b0;
        m_to    = 1'b0;
        if (m_held) begin
            if (rdy) begin
                m_held = 1'b0;
                if (ev) begin
                    m_cur.delete();
                    m_cur.push_back(b);
                    m_gap = 0;
                end
            end else if (ev) begin
                ovr_set = 1'b1;
            end
        end else if (ev) begin
            m_cur.push_back(b);
            m_gap = 0;
            if (m_cur.size() == 4) begin
                m_hw = 32'd0;
                foreach (m_cur[i]) m_hw = m_hw | (32'(m_cur[i]) << (8 * i));
                m_held = 1'b1;
                m_cur.delete();
            end
        end else if (m_cur.size() > 0) begin
            m_gap++;
            if (m_gap == TO - 1) begin
                m_cur.delete();
                m_gap = 0;
                m_to  = 1'b1;
            end
        end
        if (ovr_set) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;

        bus.i_done = d; bus.i_byte = b; bus.i_ready = rdy; bus.i_clear_err = clr;
        tick();

        checks++; if (bus.o_valid !== m_held) begin errors++; $display("FAIL rnd_valid @%0d: got %b expected %b", ecyc, bus.o_valid, m_held); end
        checks++; if (bus.o_count !== (m_held ? 3'd4 : 3'(m_cur.size()))) begin errors++; $display("FAIL rnd_count @%0d: got %0d expected %0d", ecyc, bus.o_count, m_held ? 4 : m_cur.size()); end
        checks++; if (bus.o_overrun !== m_ovr) begin errors++; $display("FAIL rnd_overrun @%0d: got %b expected %b", ecyc, bus.o_overrun, m_ovr); end
        checks++; if (bus.o_timeout !== m_to) begin errors++; $display("FAIL rnd_timeout @%0d: got %b expected %b", ecyc, bus.o_timeout, m_to); end
        if (m_held) begin
            checks++; if (bus.o_word !== m_hw) begin errors++; $display("FAIL rnd_word @%0d: got %h expected %h", ecyc, bus.o_word, m_hw); end
        end
    endtask

    task automatic test_random();
        int len;
        bus.i_done = 1'b0; bus.i_ready = 1'b0; bus.i_clear_err = 1'b0;
        apply_reset();
        m_cur.delete();
        m_held = 1'b0; m_hw = 32'd0; m_gap = 0; m_ovr = 1'b0; m_prev = 1'b0; m_to = 1'b0;
        for (int s = 0; s < 30; s++) begin
            if ($urandom_range(0, 3) == 0) begin
                len = $urandom_range(90, 130);
                for (int c = 0; c < len; c++)
                    rand_cycle(1'b0, 8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
            end else begin
                for (int c = 0; c < 40; c++)
                    rand_cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
            end
        end
        bus.i_done = 1'b0; bus.i_ready = 1'b0; bus.i_clear_err = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_long_done();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_clear_vs_set();
        test_byte_vs_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
